// File: rtl/tm_pkg.sv
// Shared constants, types and FSM encoding for the class-sum / argmax stage.
package tm_pkg;

  localparam int N_CLASS  = 12;
  localparam int N_CLAUSE = 160;
  localparam int SUM_W    = 16;
  localparam int W_W      = 9;
  localparam int CLS_W    = $clog2(N_CLASS);
  localparam int IDX_W    = $clog2(N_CLAUSE);

  typedef logic signed [SUM_W-1:0] csum_t;
  typedef logic signed [W_W-1:0]   weight_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    READ,
    DRAIN,
    ARGMAX,
    DONE
  } csa_state_t;

endpackage

// File: rtl/csum_add.sv
// Class-sum adder: csum_t plus sign-extended 9b weight.
// Saturates to the csum_t range when TM_CSUM_SAT_EN is defined, wraps otherwise.
module csum_add
  import tm_pkg::*;
(
  input  csum_t   a,
  input  weight_t w,
  output csum_t   y
);

`ifdef TM_CSUM_SAT_EN
  localparam csum_t SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam csum_t SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  // One guard bit is enough: a 9b weight can overflow a 16b sum by at most one bit.
  logic signed [SUM_W:0] full;
  assign full = {a[SUM_W-1], a} + {{(SUM_W+1-W_W){w[W_W-1]}}, w};

  always_comb begin
    if (full[SUM_W] != full[SUM_W-1]) y = full[SUM_W] ? SUM_MIN : SUM_MAX;
    else                              y = full[SUM_W-1:0];
  end
`else
  assign y = a + csum_t'(w);
`endif

endmodule

// File: rtl/class_sum_argmax.sv
// Accumulates per-class weights of fired clauses from the weight bank, then scans
// for the argmax class. Optional saturation of sums: define TM_CSUM_SAT_EN.
module class_sum_argmax
  import tm_pkg::*;
#(
  parameter  int DEPTH_WEIGHT_BANK = 2048,
  localparam int AW                = $clog2(DEPTH_WEIGHT_BANK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clause_valid,
  input  logic [IDX_W-1:0]      clause_idx,
  output logic                  clause_ready,
  input  logic                  frame_end,
  output logic [AW-1:0]         raddr_weight_bank,
  output logic                  ren_weight_bank,
  input  logic signed [W_W-1:0] weight_data,
  output logic                  busy,
  output logic                  result_valid,
  output logic [CLS_W-1:0]      result_class,
  output csum_t                 result_score
);

  csa_state_t       state, state_nx;
  logic [IDX_W-1:0] idx_q;
  logic [CLS_W-1:0] cls_cnt, cls_d, arg_cnt, best_cls, cand_cls;
  csum_t            best_score, cand_score, scan_val, add_y;
  csum_t            sums [N_CLASS];
  logic             pend_end, ren_d;
  logic             hs, idx_ok, last_cls, last_arg, take;
  logic [AW-1:0]    rd_addr;

  assign hs       = clause_valid && clause_ready;
  assign idx_ok   = clause_idx < IDX_W'(N_CLAUSE);
  assign last_cls = cls_cnt == CLS_W'(N_CLASS-1);
  assign last_arg = arg_cnt == CLS_W'(N_CLASS-1);
  assign rd_addr  = AW'(idx_q) * AW'(N_CLASS) + AW'(cls_cnt);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: default assignment first in every always_comb so no path infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = ACCUM;
      ACCUM: begin
        if (hs && idx_ok)  state_nx = READ;
        else if (frame_end) state_nx = DRAIN;
      end
      READ:   if (last_cls) state_nx = (pend_end || frame_end) ? DRAIN : ACCUM;
      DRAIN:  state_nx = ARGMAX;
      ARGMAX: if (last_arg) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clause_ready      = (state == ACCUM);
    ren_weight_bank   = (state == READ);
    raddr_weight_bank = ren_weight_bank ? rd_addr : '0;
    busy              = (state != IDLE);
    result_valid      = (state == DONE);
  end

  // Clause sequencing, read-pipeline tags and the argmax scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      cls_cnt      <= '0;
      cls_d        <= '0;
      ren_d        <= 1'b0;
      pend_end     <= 1'b0;
      arg_cnt      <= '0;
      best_cls     <= '0;
      best_score   <= '0;
      result_class <= '0;
      result_score <= '0;
    end else begin
      ren_d <= ren_weight_bank;
      if (ren_weight_bank) cls_d <= cls_cnt;
      unique case (state)
        IDLE: pend_end <= 1'b0;
        ACCUM: begin
          if (hs && idx_ok) begin
            idx_q    <= clause_idx;
            cls_cnt  <= '0;
            pend_end <= frame_end;
          end
        end
        READ: begin
          cls_cnt <= cls_cnt + 1'b1;
          if (frame_end) pend_end <= 1'b1;
        end
        DRAIN: arg_cnt <= '0;
        ARGMAX: begin
          best_cls   <= cand_cls;
          best_score <= cand_score;
          if (last_arg) begin
            arg_cnt      <= '0;
            result_class <= cand_cls;
            result_score <= cand_score;
          end else begin
            arg_cnt <= arg_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    scan_val   = sums[arg_cnt];
    take       = (arg_cnt == '0) || (scan_val > best_score);
    cand_cls   = take ? arg_cnt  : best_cls;
    cand_score = take ? scan_val : best_score;
  end

  csum_add u_add (
    .a (sums[cls_d]),
    .w (weight_data),
    .y (add_y)
  );

  // NOTE: the sum array is reset explicitly, since reset must zero every class sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CLASS; k++) sums[k] <= '0;
    end else if (state == IDLE && start) begin
      for (int k = 0; k < N_CLASS; k++) sums[k] <= '0;
    end else if (ren_d) begin
      sums[cls_d] <= add_y;
    end
  end

endmodule
